// File: rtl/ps2_input_mapper.sv
// Player-input front end: maps PS/2 key events through a loadable key map,
// merges them with joystick bits, stretches coin pulses, optionally latches pause,
// and captures DIP switch bytes from the download stream. Controls are registered (one cycle).
// CTRL_W must be at least 10 (bit 8 = coin, bit 9 = pause).
module ps2_input_mapper #(
  parameter int NUM_PLAYERS  = 2,
  parameter int CTRL_W       = 10,
  parameter int COIN_CYCLES  = 960000,
  parameter int PAUSE_TOGGLE = 1,
  parameter int MAP_INDEX    = 3,
  parameter int DIP_INDEX    = 254
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [10:0]                   i_ps2_key,
  input  logic [NUM_PLAYERS*32-1:0]     i_joystick,
  input  logic                          i_ioctl_wr,
  input  logic [15:0]                   i_ioctl_index,
  input  logic [26:0]                   i_ioctl_addr,
  input  logic [7:0]                    i_ioctl_data,
  output logic [NUM_PLAYERS*CTRL_W-1:0] o_ctrl,
  output logic [63:0]                   o_dip
);

  localparam int N_ENT     = NUM_PLAYERS * CTRL_W;
  localparam int MAP_AW    = $clog2(N_ENT);
  localparam int CNT_W     = $clog2(COIN_CYCLES + 1);
  localparam int COIN_BIT  = 8;
  localparam int PAUSE_BIT = 9;

  // Key map and DIP bytes hold their contents across reset; they power up cleared.
  logic [8:0]              r_map [N_ENT] = '{default: '0};
  logic [63:0]             r_dip = '0;
  logic                    r_old_toggle;
  logic [N_ENT-1:0]        r_key_state;
  logic [N_ENT-1:0]        r_ctrl;
  logic [CNT_W-1:0]        r_coin_cnt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]  r_coin_prev;
  logic [NUM_PLAYERS-1:0]  r_pause_prev;
  logic [NUM_PLAYERS-1:0]  r_pause;

  logic                    w_event;
  logic [N_ENT-1:0]        w_match;
  logic [N_ENT-1:0]        w_merged;
  logic [N_ENT-1:0]        w_ctrl_nxt;
  logic [NUM_PLAYERS-1:0]  w_coin_m;
  logic [NUM_PLAYERS-1:0]  w_pause_m;
  logic [NUM_PLAYERS-1:0]  w_coin_rise;
  logic [NUM_PLAYERS-1:0]  w_pause_rise;
  logic [MAP_AW-1:0]       w_map_idx;
  logic                    w_map_wr;
  logic                    w_dip_wr;
  logic                    w_unused_joy;

  assign w_event   = i_ps2_key[10] != r_old_toggle;
  assign w_map_idx = i_ioctl_addr[MAP_AW:1];
  assign w_map_wr  = i_ioctl_wr && (i_ioctl_index == 16'(MAP_INDEX)) &&
                     (i_ioctl_addr < 27'(2 * N_ENT));
  assign w_dip_wr  = i_ioctl_wr && (i_ioctl_index == 16'(DIP_INDEX)) &&
                     (i_ioctl_addr[24:3] == '0);
  // Joystick bits beyond the mapped controls are intentionally ignored.
  assign w_unused_joy = ^i_joystick;

  // Per-entry match against the current (pre-write) map, and key/joystick merge.
  for (genvar e = 0; e < N_ENT; e++) begin : g_ent
    assign w_match[e]  = (r_map[e][7:0] != 8'h00) && (r_map[e] == i_ps2_key[8:0]);
    assign w_merged[e] = r_key_state[e] | i_joystick[(e / CTRL_W) * 32 + (e % CTRL_W)];
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign w_coin_m[p]     = w_merged[p * CTRL_W + COIN_BIT];
    assign w_pause_m[p]    = w_merged[p * CTRL_W + PAUSE_BIT];
    assign w_coin_rise[p]  = w_coin_m[p] & ~r_coin_prev[p];
    assign w_pause_rise[p] = w_pause_m[p] & ~r_pause_prev[p];
  end

  // Key map load: even byte address carries the scan code, odd byte the extended flag.
  always_ff @(posedge i_clk) begin
    if (w_map_wr) begin
      if (i_ioctl_addr[0]) r_map[w_map_idx][8]   <= i_ioctl_data[0];
      else                 r_map[w_map_idx][7:0] <= i_ioctl_data;
    end
  end

  // DIP byte capture from the first eight addresses of the DIP download.
  always_ff @(posedge i_clk) begin
    if (w_dip_wr) r_dip[{i_ioctl_addr[2:0], 3'b000} +: 8] <= i_ioctl_data;
  end

  // Toggle tracker runs through reset so releasing reset never fakes an event.
  always_ff @(posedge i_clk) begin
    r_old_toggle <= i_ps2_key[10];
  end

  // Key state: every matching entry takes the pressed flag of the event.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_key_state <= '0;
    else if (w_event) r_key_state <= (r_key_state & ~w_match) |
                                     (w_match & {N_ENT{i_ps2_key[9]}});
  end

  // Coin stretch counters, pause latches and their edge detectors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_coin_prev  <= '0;
      r_pause_prev <= '0;
      r_pause      <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) r_coin_cnt[p] <= '0;
    end else begin
      r_coin_prev  <= w_coin_m;
      r_pause_prev <= w_pause_m;
      r_pause      <= r_pause ^ w_pause_rise;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (w_coin_rise[p])            r_coin_cnt[p] <= CNT_W'(COIN_CYCLES - 1);
        else if (r_coin_cnt[p] != '0)  r_coin_cnt[p] <= r_coin_cnt[p] - CNT_W'(1);
      end
    end
  end

  // Next control word: merged bits, with coin stretched and pause optionally latched.
  always_comb begin
    w_ctrl_nxt = w_merged;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_ctrl_nxt[p * CTRL_W + COIN_BIT] = w_coin_m[p] | (r_coin_cnt[p] != '0);
      if (PAUSE_TOGGLE != 0)
        w_ctrl_nxt[p * CTRL_W + PAUSE_BIT] = r_pause[p] ^ w_pause_rise[p];
    end
  end

  // Registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_ctrl <= '0;
    else         r_ctrl <= w_ctrl_nxt;
  end

  assign o_ctrl = r_ctrl;
  assign o_dip  = r_dip;

endmodule

// File: tb/tb_ps2_input_mapper.sv
// Directed bench for ps2_input_mapper: key map decode, merge, coin stretch,
// pause toggle/level, DIP capture, reset behaviour and map/event ordering.
module tb_ps2_input_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [63:0] joystick;
  logic        ioctl_wr;
  logic [15:0] ioctl_index;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [19:0] ctrl, ctrl_l;
  logic [63:0] dip, dip_l;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ps2_input_mapper #(.NUM_PLAYERS(2), .CTRL_W(10), .COIN_CYCLES(16), .PAUSE_TOGGLE(1),
                     .MAP_INDEX(3), .DIP_INDEX(254)) dut (
    .i_clk(clk), .i_reset(reset), .i_ps2_key(ps2_key), .i_joystick(joystick),
    .i_ioctl_wr(ioctl_wr), .i_ioctl_index(ioctl_index), .i_ioctl_addr(ioctl_addr),
    .i_ioctl_data(ioctl_data), .o_ctrl(ctrl), .o_dip(dip));

  ps2_input_mapper #(.NUM_PLAYERS(2), .CTRL_W(10), .COIN_CYCLES(16), .PAUSE_TOGGLE(0),
                     .MAP_INDEX(3), .DIP_INDEX(254)) dut_lvl (
    .i_clk(clk), .i_reset(reset), .i_ps2_key(ps2_key), .i_joystick(joystick),
    .i_ioctl_wr(ioctl_wr), .i_ioctl_index(ioctl_index), .i_ioctl_addr(ioctl_addr),
    .i_ioctl_data(ioctl_data), .o_ctrl(ctrl_l), .o_dip(dip_l));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [15:0] ix, input logic [26:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_index = ix; ioctl_addr = a; ioctl_data = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic map_entry(input int e, input logic ext, input logic [7:0] code);
    wr_byte(16'd3, 27'(2 * e), code);
    wr_byte(16'd3, 27'(2 * e + 1), {7'd0, ext});
  endtask

  // Issue a key event and wait until ctrl reflects it.
  task automatic key(input logic pr, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
    tick();
    tick();
  endtask

  // Drive coin (player 0) high in two windows and count ctrl[8] high samples.
  task automatic coin_run(input int a1, input int b1, input int a2, input int b2,
                          output int tot, output int after);
    tot = 0; after = 0;
    for (int i = 0; i < 60; i++) begin
      joystick[8] = ((i >= a1) && (i < b1)) || ((i >= a2) && (i < b2));
      tick();
      if (ctrl[8]) begin
        tot++;
        if (i >= a2) after++;
      end
    end
    joystick[8] = 1'b0;
  endtask

  int tot, after;

  initial begin
    reset = 1'b1; ps2_key = '0; joystick = '0;
    ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_data = '0;
    repeat (3) tick();
    chk("reset_ctrl", 64'(ctrl), 64'h0);
    chk("reset_ctrl_lvl", 64'(ctrl_l), 64'h0);
    chk("powerup_dip", dip, 64'h0);
    reset = 1'b0;
    tick();

    map_entry(0, 1'b0, 8'h74);
    map_entry(3, 1'b1, 8'h75);
    map_entry(4, 1'b0, 8'h14);
    map_entry(14, 1'b0, 8'h14);

    // Press 0x74: visible after the second edge, not after the first.
    ps2_key = {~ps2_key[10], 10'h274};
    tick();
    chk("key_latency_1", 64'(ctrl), 64'h0);
    tick();
    chk("key_press_74", 64'(ctrl), 64'h1);
    key(1'b0, 1'b0, 8'h74);
    chk("key_release_74", 64'(ctrl), 64'h0);
    key(1'b1, 1'b1, 8'h75);
    chk("ext_press_75", 64'(ctrl), 64'h8);
    key(1'b0, 1'b0, 8'h75);
    chk("nonext_75_ignored", 64'(ctrl), 64'h8);
    key(1'b0, 1'b1, 8'h75);
    chk("ext_release_75", 64'(ctrl), 64'h0);
    key(1'b1, 1'b0, 8'h14);
    chk("multi_match_14", 64'(ctrl), 64'h4010);
    chk("multi_match_14_lvl", 64'(ctrl_l), 64'h4010);
    key(1'b1, 1'b0, 8'h1C);
    chk("unmapped_1c", 64'(ctrl), 64'h4010);
    key(1'b0, 1'b0, 8'h14);
    chk("multi_release_14", 64'(ctrl), 64'h0);

    // Player 1 joystick right lands on ctrl[10] one edge later.
    joystick[32] = 1'b1;
    tick();
    chk("joy_p1_right", 64'(ctrl), 64'h400);
    joystick[32] = 1'b0;
    tick();
    chk("joy_p1_release", 64'(ctrl), 64'h0);

    // Coin stretch.
    coin_run(0, 3, 100, 100, tot, after);
    chk("coin_short", 64'(tot), 64'd16);
    coin_run(0, 40, 100, 100, tot, after);
    chk("coin_held40", 64'(tot), 64'd40);
    coin_run(0, 1, 6, 7, tot, after);
    chk("coin_repress_total", 64'(tot), 64'd22);
    chk("coin_repress_after", 64'(after), 64'd16);

    // Pause: toggle in dut, level in dut_lvl.
    joystick[9] = 1'b1;
    tick(); tick();
    chk("pause_tgl_press1", 64'(ctrl[9]), 64'd1);
    chk("pause_lvl_press1", 64'(ctrl_l[9]), 64'd1);
    joystick[9] = 1'b0;
    tick(); tick();
    chk("pause_tgl_rel1", 64'(ctrl[9]), 64'd1);
    chk("pause_lvl_rel1", 64'(ctrl_l[9]), 64'd0);
    joystick[9] = 1'b1;
    tick(); tick();
    joystick[9] = 1'b0;
    tick(); tick();
    chk("pause_tgl_press2", 64'(ctrl[9]), 64'd0);
    chk("pause_lvl_rel2", 64'(ctrl_l[9]), 64'd0);

    // DIP capture.
    for (int i = 0; i < 8; i++) wr_byte(16'd254, 27'(i), 8'(8'hA0 + i));
    tick();
    chk("dip_load", dip, 64'hA7A6A5A4A3A2A1A0);
    wr_byte(16'd254, 27'd8, 8'hFF);
    wr_byte(16'd5, 27'd0, 8'h55);
    tick();
    chk("dip_ignored", dip, 64'hA7A6A5A4A3A2A1A0);

    // Key held plus coin mid-stretch, then reset with a toggle during reset.
    key(1'b1, 1'b0, 8'h74);
    joystick[8] = 1'b1;
    tick();
    joystick[8] = 1'b0;
    tick();
    chk("pre_reset_ctrl", 64'(ctrl), 64'h101);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 10'h274};
    tick();
    chk("in_reset_ctrl", 64'(ctrl), 64'h0);
    chk("in_reset_dip", dip, 64'hA7A6A5A4A3A2A1A0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_reset_ctrl", 64'(ctrl), 64'h0);
    key(1'b1, 1'b0, 8'h74);
    chk("post_reset_press", 64'(ctrl), 64'h1);
    key(1'b0, 1'b0, 8'h74);
    chk("post_reset_release", 64'(ctrl), 64'h0);

    // Map write coincident with an event for the same code uses the old map.
    ioctl_wr = 1'b1; ioctl_index = 16'd3; ioctl_addr = 27'd0; ioctl_data = 8'h1C;
    ps2_key = {~ps2_key[10], 10'h274};
    tick();
    ioctl_wr = 1'b0;
    tick();
    chk("coincident_old_map", 64'(ctrl), 64'h1);
    key(1'b0, 1'b0, 8'h74);
    chk("new_map_74_gone", 64'(ctrl), 64'h1);
    key(1'b0, 1'b0, 8'h1C);
    chk("new_map_1c", 64'(ctrl), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
